// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receive and transmit sides.
package uart_pkg;

  // Receiver/transmitter frame-level states.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;

  localparam int PARITY_EVEN = 0;
  localparam int PARITY_ODD  = 1;

  // 48 MHz system clock / 9600 bps.
  localparam int DEFAULT_CLKS_PER_BIT = 5000;

  // Offset from the start-bit edge to its middle, in clock cycles.
  function automatic int half_period(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RX pin; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic line,
  output logic synced
);

  logic meta;

  // Double-register the line so downstream logic never sees a metastable value.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta   <= 1'b1;
      synced <= 1'b1;
    end else begin
      meta   <= line;
      synced <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receiver: start bit, LSB-first data, optional parity, one stop bit.
// Generates its own mid-bit sample timing from the system clock.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int PARITY_ENABLED   = 1,
  parameter int PARITY_TYPE      = PARITY_EVEN,
  parameter int CLKS_PER_BIT     = DEFAULT_CLKS_PER_BIT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        serial_in,
  output logic [INPUT_DATA_WIDTH-1:0] o_data,
  output logic                        o_valid,
  output logic                        o_parity_err,
  output logic                        o_frame_err,
  output logic                        o_busy
);

  localparam int N  = INPUT_DATA_WIDTH;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(N) + 1;

  localparam logic [CW-1:0] HALF_LAST = CW'(half_period(CLKS_PER_BIT) - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);
  localparam logic          PAR_EN    = (PARITY_ENABLED != 0);
  localparam logic          PAR_ODD   = (PARITY_TYPE != PARITY_EVEN);

  logic          sync_in;
  state_t        state;
  logic [CW-1:0] bit_cnt;
  logic [IW-1:0] bit_idx;
  logic [N-1:0]  shreg;
  logic          par_err;
  logic          sample;

  uart_rx_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .line   (serial_in),
    .synced (sync_in)
  );

  assign o_busy = (state != IDLE);

  // Sample point: half a bit into the start bit, then one full bit period per bit.
  always_comb begin
    sample = 1'b0;
    case (state)
      START:              sample = (bit_cnt == HALF_LAST);
      DATA, PARITY, STOP: sample = (bit_cnt == BIT_LAST);
      default:            sample = 1'b0;
    endcase
  end

  // Frame FSM with bit timing, shift register, parity check and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      par_err      <= 1'b0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (sample) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (!sync_in) begin
            state <= START;
          end
        end

        START: begin
          if (sample) begin
            if (sync_in) begin
              // Low pulse shorter than half a bit: a glitch, not a start bit.
              state <= IDLE;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end
        end

        DATA: begin
          if (sample) begin
            shreg   <= {sync_in, shreg[N-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == IDX_LAST) begin
              state <= PAR_EN ? PARITY : STOP;
            end
          end
        end

        PARITY: begin
          if (sample) begin
            par_err <= (sync_in != ((^shreg) ^ PAR_ODD));
            state   <= STOP;
          end
        end

        STOP: begin
          if (sample) begin
            o_valid      <= 1'b1;
            o_data       <= shreg;
            o_parity_err <= PAR_EN & par_err;
            o_frame_err  <= ~sync_in;
            // Leaving on the stop-bit midpoint lets the next start bit follow immediately.
            state        <= sync_in ? IDLE : WAIT_IDLE;
          end
        end

        WAIT_IDLE: begin
          bit_cnt <= '0;
          if (sync_in) begin
            state <= IDLE;
          end
        end

        default: begin
          state   <= IDLE;
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboard bench for uart_rx_deserializer: even- and odd-parity instances share one serial line.
module tb_uart_rx_deserializer;

  localparam int CPB = 16;
  // 2 (sync) + 1 (drive-to-capture) + 8 (half) + 10*16 (data+parity) = stop sample edge; o_valid seen there.
  localparam longint LAT = 171;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    longint     cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       serial_in = 1'b1;
  logic [7:0] o_data [2];
  logic       o_valid [2];
  logic       o_perr [2];
  logic       o_ferr [2];
  logic       o_busy [2];

  exp_t   q [2][$];
  longint cyc = 0;
  int     n_cmp = 0;
  int     n_bad = 0;
  logic   last_perr [2];
  logic   last_ferr;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_deserializer #(
    .INPUT_DATA_WIDTH (8),
    .PARITY_ENABLED   (1),
    .PARITY_TYPE      (0),
    .CLKS_PER_BIT     (CPB)
  ) dut_even (
    .clk          (clk),
    .reset        (reset),
    .serial_in    (serial_in),
    .o_data       (o_data[0]),
    .o_valid      (o_valid[0]),
    .o_parity_err (o_perr[0]),
    .o_frame_err  (o_ferr[0]),
    .o_busy       (o_busy[0])
  );

  uart_rx_deserializer #(
    .INPUT_DATA_WIDTH (8),
    .PARITY_ENABLED   (1),
    .PARITY_TYPE      (1),
    .CLKS_PER_BIT     (CPB)
  ) dut_odd (
    .clk          (clk),
    .reset        (reset),
    .serial_in    (serial_in),
    .o_data       (o_data[1]),
    .o_valid      (o_valid[1]),
    .o_parity_err (o_perr[1]),
    .o_frame_err  (o_ferr[1]),
    .o_busy       (o_busy[1])
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every o_valid pulse pops and checks one expected frame.
  always @(negedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        if (o_valid[k] === 1'b1) begin
          if (q[k].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_valid dut%0d: got valid with data %0h, required no valid (cycle %0d)",
                     k, o_data[k], cyc);
          end else begin
            exp_t e;
            e = q[k].pop_front();
            check($sformatf("data dut%0d", k), longint'(o_data[k]), longint'(e.data));
            check($sformatf("parity_err dut%0d", k), longint'(o_perr[k]), longint'(e.perr));
            check($sformatf("frame_err dut%0d", k), longint'(o_ferr[k]), longint'(e.ferr));
            check($sformatf("latency dut%0d", k), cyc, e.cyc);
          end
        end
      end
    end
  end

  // Caller is aligned 1 time unit after a posedge; leaves alignment unchanged.
  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit,
                            input logic pe_even, input logic pe_odd, input logic expect_valid);
    logic [10:0] bits;
    exp_t e;
    bits = {sbit, pbit, d, 1'b0};
    if (expect_valid) begin
      e.data = d;
      e.ferr = ~sbit;
      e.cyc  = cyc + LAT;
      e.perr = pe_even;
      q[0].push_back(e);
      e.perr = pe_odd;
      q[1].push_back(e);
      last_perr[0] = pe_even;
      last_perr[1] = pe_odd;
      last_ferr    = ~sbit;
    end
    for (int i = 0; i < 11; i++) begin
      serial_in = bits[i];
      idle_cycles(CPB);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s data dut%0d", tag, k), longint'(o_data[k]), 0);
      check($sformatf("%s valid dut%0d", tag, k), longint'(o_valid[k]), 0);
      check($sformatf("%s perr dut%0d", tag, k), longint'(o_perr[k]), 0);
      check($sformatf("%s ferr dut%0d", tag, k), longint'(o_ferr[k]), 0);
      check($sformatf("%s busy dut%0d", tag, k), longint'(o_busy[k]), 0);
    end
  endtask

  initial begin
    logic [7:0] partial;
    partial = 8'h81;

    // 1. Reset and idle line.
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    idle_cycles(500);
    check_all_zero("idle");

    // 2. 0xA5, parity 0 (four ones): even ok, odd flags error.
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    serial_in = 1'b1;
    idle_cycles(30);

    // 3. 0x3C with parity bit 1: even flags error, odd ok.
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    serial_in = 1'b1;
    idle_cycles(30);

    // 4. 0x55 with stop bit 0, then break held low.
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle_cycles(100);
    check("busy_in_break dut0", longint'(o_busy[0]), 1);
    check("busy_in_break dut1", longint'(o_busy[1]), 1);
    serial_in = 1'b1;
    idle_cycles(20);
    check("idle_after_break dut0", longint'(o_busy[0]), 0);
    // 0x07 has three ones: parity 1 is correct for even, wrong for odd.
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    serial_in = 1'b1;
    idle_cycles(30);

    // 5. Glitch shorter than half a bit.
    serial_in = 1'b0;
    idle_cycles(4);
    serial_in = 1'b1;
    idle_cycles(40);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("glitch busy dut%0d", k), longint'(o_busy[k]), 0);
      check($sformatf("glitch perr held dut%0d", k), longint'(o_perr[k]), longint'(last_perr[k]));
      check($sformatf("glitch ferr held dut%0d", k), longint'(o_ferr[k]), longint'(last_ferr));
      check($sformatf("glitch data held dut%0d", k), longint'(o_data[k]), 8'h07);
    end
    // Back-to-back: 0x00 (parity 0) then 0xFF (parity 1, even has eight ones -> wrong for even).
    send_frame(8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    serial_in = 1'b1;
    idle_cycles(30);

    // 6. Reset during data bit 3 of 0x81.
    serial_in = 1'b0;
    idle_cycles(CPB);
    for (int i = 0; i < 3; i++) begin
      serial_in = partial[i];
      idle_cycles(CPB);
    end
    serial_in = partial[3];
    idle_cycles(CPB / 2);
    check("busy_before_reset dut0", longint'(o_busy[0]), 1);
    reset = 1'b1;
    serial_in = 1'b1;
    idle_cycles(1);
    reset = 1'b0;
    check_all_zero("after_reset");
    idle_cycles(40);
    // 0x7E has six ones: parity 0 correct for even.
    send_frame(8'h7E, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    serial_in = 1'b1;
    idle_cycles(40);

    for (int k = 0; k < 2; k++) begin
      check($sformatf("pending_frames dut%0d", k), longint'(q[k].size()), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
